mm_array_ctrl: RTL

Sequencer for an N x N systolic array of minifloat MAC processing elements (8-bit: sign, 3-bit exponent, 4-bit fraction).
- Holds operand matrices A and B in local buffers loaded over a simple write port.
- On start: clears the array, streams skewed operands into the array's left (A) and top (B) edges, waits for the pipeline to drain, then captures the N*N results into readable registers.
- Sits between the host/load logic and the PE array wrapper.

---
 rtl/mm_array_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mm_array_ctrl.sv
// ---------------------------------------------------------------------------
// mm_array_ctrl
//
// Sequencer for an N x N systolic array of 8-bit minifloat MAC PEs.
// Holds operand matrices A and B, streams them skewed into the array edges,
// waits for the array pipeline to drain and then captures the N*N results.
//
// Ports
//   clk, rst         : clock (rising edge), synchronous active-high reset
//   start            : begin a multiply; only looked at while idle
//   ld_we/ld_mat     : operand buffer write (0 = A, 1 = B), dropped while busy
//   ld_row/ld_col    : element index of the write (index >= N is dropped)
//   ld_data          : minifloat element to store
//   a_edge           : row i operand at [i*8 +: 8] to the left PE column
//   b_edge           : column j operand at [j*8 +: 8] to the top PE row
//   array_clr        : accumulator clear pulse to the array wrapper
//   res_in           : PE results, element (i,j) at [(i*N+j)*8 +: 8]
//   rd_row/rd_col    : captured-result read index
//   rd_data          : combinational read of the captured result (0 if out of range)
//   busy             : high from CLEAR through CAPTURE
//   done             : single-cycle pulse after the results are captured
//   dbg_state        : current FSM state, for observation only
//
// Handshake: start is a level sampled on a rising edge while the FSM is
// idle; a start seen while busy is discarded, never queued. done rises in the
// first idle cycle after capture, and a start in that cycle is accepted.
// ---------------------------------------------------------------------------
module mm_array_ctrl #(
    parameter int N      = 2,
    parameter int PE_LAT = 2,
    parameter int IDXW   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               ld_we,
    input  logic               ld_mat,
    input  logic [IDXW-1:0]    ld_row,
    input  logic [IDXW-1:0]    ld_col,
    input  logic [7:0]         ld_data,
    output logic [N*8-1:0]     a_edge,
    output logic [N*8-1:0]     b_edge,
    output logic               array_clr,
    input  logic [N*N*8-1:0]   res_in,
    input  logic [IDXW-1:0]    rd_row,
    input  logic [IDXW-1:0]    rd_col,
    output logic [7:0]         rd_data,
    output logic               busy,
    output logic               done,
    output logic [2:0]         dbg_state
);

    localparam int F    = N + (N - 1) * PE_LAT;          // feed cycles
    localparam int D    = (2 * (N - 1) + 1) * PE_LAT;    // drain cycles
    localparam int CMAX = (F > D) ? F : D;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int MW   = N * N * 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_FEED    = 3'd2,
        S_DRAIN   = 3'd3,
        S_CAPTURE = 3'd4
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   fcnt_q;
    logic [CW-1:0]   fcnt_d;
    logic [CW-1:0]   dcnt_q;
    logic [MW-1:0]   a_q;
    logic [MW-1:0]   b_q;
    logic [MW-1:0]   res_q;
    logic [N*8-1:0]  a_edge_q;
    logic [N*8-1:0]  b_edge_q;
    logic [N*8-1:0]  a_edge_d;
    logic [N*8-1:0]  b_edge_d;
    logic            array_clr_q;
    logic            busy_q;
    logic            done_q;

    logic            ld_ok;
    int              ld_idx;
    logic            rd_ok;
    int              rd_idx;

    // Row i of A enters the array i*PE_LAT cycles late so that its elements
    // meet the matching B elements inside the PE grid.
    function automatic logic [N*8-1:0] a_slice(input int f, input logic [MW-1:0] m);
        logic [N*8-1:0] r;
        int k;
        r = '0;
        for (int i = 0; i < N; i++) begin
            k = f - i * PE_LAT;
            if (k >= 0 && k < N) r[i*8 +: 8] = m[(i*N + k)*8 +: 8];
        end
        return r;
    endfunction

    // Column j of B is skewed the same way, walking down the rows.
    function automatic logic [N*8-1:0] b_slice(input int f, input logic [MW-1:0] m);
        logic [N*8-1:0] r;
        int k;
        r = '0;
        for (int j = 0; j < N; j++) begin
            k = f - j * PE_LAT;
            if (k >= 0 && k < N) r[j*8 +: 8] = m[(k*N + j)*8 +: 8];
        end
        return r;
    endfunction

    // Edge values are registered, so they are computed from the feed count
    // that will be current in the next cycle.
    always_comb begin
        fcnt_d   = (state_q == S_CLEAR) ? '0 : fcnt_q + CW'(1);
        a_edge_d = a_slice(int'(fcnt_d), a_q);
        b_edge_d = b_slice(int'(fcnt_d), b_q);
    end

    always_comb begin
        ld_ok  = (int'(ld_row) < N) && (int'(ld_col) < N);
        ld_idx = 0;
        if (ld_ok) ld_idx = int'(ld_row) * N + int'(ld_col);
        rd_ok  = (int'(rd_row) < N) && (int'(rd_col) < N);
        rd_idx = 0;
        if (rd_ok) rd_idx = int'(rd_row) * N + int'(rd_col);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            fcnt_q      <= '0;
            dcnt_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            a_edge_q    <= '0;
            b_edge_q    <= '0;
            array_clr_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            a_edge_q    <= '0;
            b_edge_q    <= '0;
            array_clr_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // A write alongside start lands before the first feed
                    // cycle reads the buffers, so the run sees it.
                    if (ld_we && ld_ok) begin
                        if (ld_mat) b_q[ld_idx*8 +: 8] <= ld_data;
                        else        a_q[ld_idx*8 +: 8] <= ld_data;
                    end
                    if (start) begin
                        state_q     <= S_CLEAR;
                        busy_q      <= 1'b1;
                        array_clr_q <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state_q  <= S_FEED;
                    fcnt_q   <= fcnt_d;
                    a_edge_q <= a_edge_d;
                    b_edge_q <= b_edge_d;
                end
                S_FEED: begin
                    if (fcnt_q == CW'(F - 1)) begin
                        state_q <= S_DRAIN;
                        dcnt_q  <= '0;
                    end else begin
                        fcnt_q   <= fcnt_d;
                        a_edge_q <= a_edge_d;
                        b_edge_q <= b_edge_d;
                    end
                end
                S_DRAIN: begin
                    // The capture cycle is the last of the D drain cycles, so
                    // the drain state itself only spans D-1 of them.
                    if (dcnt_q == CW'(D - 2)) state_q <= S_CAPTURE;
                    else                      dcnt_q  <= dcnt_q + CW'(1);
                end
                S_CAPTURE: begin
                    res_q   <= res_in;
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign a_edge    = a_edge_q;
    assign b_edge    = b_edge_q;
    assign array_clr = array_clr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;
    assign rd_data   = rd_ok ? res_q[rd_idx*8 +: 8] : 8'h00;

endmodule
